register_file_access_controller: RTL and testbench

Parametrised, pipelined successor to the register-file select decoder. It decodes each 8-bit instruction into register read/write selects and absorbs the two-instruction MOV sequence into an internal state machine. A per-register write scoreboard stalls the issue stage on read-after-write and write-after-write hazards. It emits register-file write strobes delayed to match the datapath writeback latency. It sits between instruction fetch and the register file / ALU issue stage.

---
 rtl/opcode_pkg.sv | 31 +++
 rtl/regfile_scoreboard.sv | 73 +++++++
 rtl/register_file_access_controller.sv | 151 +++++++++++++++
 tb/tb_register_file_access_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opcode_pkg.sv
// Opcode encoding shared by the instruction decoder and its users, plus the
// MOV sequencing state and the bubble encoding.
package opcode_pkg;

  typedef enum logic [3:0] {
    OPCODE_ADD  = 4'h0,
    OPCODE_ADDI = 4'h1,
    OPCODE_SUB  = 4'h2,
    OPCODE_SUBI = 4'h3,
    OPCODE_AND  = 4'h4,
    OPCODE_OR   = 4'h5,
    OPCODE_XOR  = 4'h6,
    OPCODE_NOT  = 4'h7,
    OPCODE_LSL  = 4'h8,
    OPCODE_LSR  = 4'h9,
    OPCODE_LDUR = 4'hA,
    OPCODE_STUR = 4'hB,
    OPCODE_CMP  = 4'hC,
    OPCODE_BR   = 4'hD,
    OPCODE_MOV1 = 4'hE,
    OPCODE_MOV2 = 4'hF
  } opcode_t;

  typedef enum logic {
    MOV_IDLE = 1'b0,
    MOV_PEND = 1'b1
  } mov_state_t;

  localparam logic [7:0] BUBBLE_INSTR = 8'h00;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register write-in-flight scoreboard: busy mask, writeback delay pipe
// and the hazard compare against the instruction being considered for issue.
module regfile_scoreboard #(
  parameter int NUM_REGS   = 8,
  parameter int WB_LATENCY = 2,
  parameter int SEL_W      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd1_live,
  input  logic [SEL_W-1:0]    rd1_sel,
  input  logic                rd2_live,
  input  logic [SEL_W-1:0]    rd2_sel,
  input  logic                wr_live,
  input  logic [SEL_W-1:0]    wr_sel,
  input  logic                push,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                wb_write_enable,
  output logic [SEL_W-1:0]    wb_write_select
);

  localparam logic [NUM_REGS-1:0] ONE_HOT = NUM_REGS'(1);

  logic [WB_LATENCY-1:0] pipe_vld;
  logic [SEL_W-1:0]      pipe_sel [WB_LATENCY];
  logic [NUM_REGS-1:0]   set_vec;
  logic [NUM_REGS-1:0]   clr_vec;

  // NOTE: always_comb assigns every output a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hazard = 1'b0;
    if (rd1_live && busy_mask[rd1_sel]) hazard = 1'b1;
    if (rd2_live && busy_mask[rd2_sel]) hazard = 1'b1;
    if (wr_live  && busy_mask[wr_sel])  hazard = 1'b1;
  end

  always_comb begin
    set_vec = push            ? (ONE_HOT << wr_sel)          : '0;
    clr_vec = wb_write_enable ? (ONE_HOT << wb_write_select) : '0;
  end

  // NOTE: the delay pipe is a small register array that is reset on purpose:
  // a reset must drop every in-flight writeback, not just the busy bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < WB_LATENCY; i++) pipe_sel[i] <= '0;
    end else begin
      pipe_vld[0] <= push;
      pipe_sel[0] <= wr_sel;
      for (int i = 1; i < WB_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_sel[i] <= pipe_sel[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_mask <= '0;
    else        busy_mask <= (busy_mask & ~clr_vec) | set_vec;
  end

  assign wb_write_enable = pipe_vld[WB_LATENCY-1];
  assign wb_write_select = pipe_sel[WB_LATENCY-1];

  // The write-after-write stall guarantees a register is never set and
  // cleared in the same cycle.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && wb_write_enable && (wr_sel == wb_write_select)));

endmodule

// File: rtl/register_file_access_controller.sv
// Instruction decode to register selects, MOV pair sequencing, hazard stall
// and latency-matched register-file write strobes. NUM_REGS >= 8, WB_LATENCY >= 1.
module register_file_access_controller
  import opcode_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int WB_LATENCY = 2,
  parameter int SEL_W      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          instruction,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                enabled,
  output logic [SEL_W-1:0]    read_select_1,
  output logic [SEL_W-1:0]    read_select_2,
  output logic                wb_write_enable,
  output logic [SEL_W-1:0]    wb_write_select,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                mov_pending,
  output logic                mov_seq_err
);

  opcode_t    op;
  logic [3:0] d;
  logic       is_bubble;
  mov_state_t mov_state, mov_state_next;
  logic [2:0] mov_src;

  logic             rd1_live, rd2_live, wr_live;
  logic [SEL_W-1:0] rd1_sel, rd2_sel, wr_sel;
  logic             seq_err_set;
  logic             hazard, issue, push;

  assign op        = opcode_t'(instruction[7:4]);
  assign d         = instruction[3:0];
  assign is_bubble = (instruction == BUBBLE_INSTR);

  always_comb begin
    rd1_live    = 1'b0;
    rd2_live    = 1'b0;
    wr_live     = 1'b0;
    rd1_sel     = '0;
    rd2_sel     = '0;
    wr_sel      = '0;
    seq_err_set = 1'b0;
    if (!is_bubble) begin
      case (op)
        OPCODE_ADD, OPCODE_ADDI, OPCODE_SUB, OPCODE_SUBI, OPCODE_AND,
        OPCODE_OR, OPCODE_XOR, OPCODE_NOT, OPCODE_LSL, OPCODE_LSR: begin
          rd1_live = 1'b1;
          rd2_live = 1'b1;
          wr_live  = 1'b1;
          rd1_sel  = SEL_W'({2'b00, d[2]});
          rd2_sel  = SEL_W'({1'b0, d[1:0]});
          wr_sel   = SEL_W'({2'b01, d[3]});
        end
        OPCODE_LDUR: begin
          rd1_live = 1'b1;
          wr_live  = 1'b1;
          rd1_sel  = SEL_W'({1'b0, d[1:0]});
          wr_sel   = SEL_W'({1'b0, d[3:2]});
        end
        OPCODE_STUR: begin
          rd1_live = 1'b1;
          rd2_live = 1'b1;
          rd1_sel  = SEL_W'({1'b0, d[1:0]});
          rd2_sel  = SEL_W'({1'b0, d[3:2]});
        end
        OPCODE_CMP: begin
          rd1_live = 1'b1;
          rd2_live = 1'b1;
          rd1_sel  = SEL_W'({1'b0, d[3:2]});
          rd2_sel  = SEL_W'({1'b0, d[1:0]});
        end
        OPCODE_BR: begin
          rd1_live = 1'b1;
          rd1_sel  = SEL_W'({1'b1, d[1:0]});
        end
        OPCODE_MOV2: begin
          // Without a latched source the MOV2 is an orphan: flagged, no write.
          if (mov_state == MOV_PEND) begin
            rd1_live = 1'b1;
            wr_live  = 1'b1;
            rd1_sel  = SEL_W'(mov_src);
            wr_sel   = SEL_W'(d[2:0]);
          end else begin
            seq_err_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign read_select_1 = rd1_sel;
  assign read_select_2 = rd2_sel;

  assign instr_ready = is_bubble || !enabled || !hazard;
  assign issue       = instr_valid && instr_ready && enabled && !is_bubble;
  assign push        = issue && wr_live;

  always_comb begin
    mov_state_next = mov_state;
    if (issue) begin
      case (op)
        OPCODE_MOV1: mov_state_next = MOV_PEND;
        OPCODE_MOV2: mov_state_next = MOV_IDLE;
        default:     ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mov_state   <= MOV_IDLE;
      mov_src     <= '0;
      mov_seq_err <= 1'b0;
    end else begin
      mov_state <= mov_state_next;
      if (issue && op == OPCODE_MOV1) mov_src <= d[2:0];
      if (issue && seq_err_set)       mov_seq_err <= 1'b1;
    end
  end

  assign mov_pending = (mov_state == MOV_PEND);

  regfile_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .WB_LATENCY (WB_LATENCY),
    .SEL_W      (SEL_W)
  ) u_scoreboard (
    .clk             (clk),
    .rst_n           (rst_n),
    .rd1_live        (rd1_live),
    .rd1_sel         (rd1_sel),
    .rd2_live        (rd2_live),
    .rd2_sel         (rd2_sel),
    .wr_live         (wr_live),
    .wr_sel          (wr_sel),
    .push            (push),
    .hazard          (hazard),
    .busy_mask       (busy_mask),
    .wb_write_enable (wb_write_enable),
    .wb_write_select (wb_write_select)
  );

endmodule

// File: tb/tb_register_file_access_controller.sv
// Directed bench for register_file_access_controller: decode, hazards,
// MOV sequencing, bubbles, issue enable and mid-flight reset.
module tb_register_file_access_controller;
  import opcode_pkg::*;

  localparam int NUM_REGS   = 8;
  localparam int WB_LATENCY = 2;
  localparam int SEL_W      = 3;

  logic                clk;
  logic                rst_n;
  logic [7:0]          instruction;
  logic                instr_valid;
  logic                instr_ready;
  logic                enabled;
  logic [SEL_W-1:0]    read_select_1;
  logic [SEL_W-1:0]    read_select_2;
  logic                wb_write_enable;
  logic [SEL_W-1:0]    wb_write_select;
  logic [NUM_REGS-1:0] busy_mask;
  logic                mov_pending;
  logic                mov_seq_err;

  int total;
  int bad;

  register_file_access_controller #(
    .NUM_REGS   (NUM_REGS),
    .WB_LATENCY (WB_LATENCY)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instruction     (instruction),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .enabled         (enabled),
    .read_select_1   (read_select_1),
    .read_select_2   (read_select_2),
    .wb_write_enable (wb_write_enable),
    .wb_write_select (wb_write_select),
    .busy_mask       (busy_mask),
    .mov_pending     (mov_pending),
    .mov_seq_err     (mov_seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one instruction and let combinational outputs settle.
  task automatic apply(input logic [7:0] ins, input logic vld);
    instruction = ins;
    instr_valid = vld;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    enabled     = 1'b1;
    instr_valid = 1'b0;
    instruction = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_mask, 8'h00);
    check("rst_wb_en", wb_write_enable, 1'b0);
    check("rst_wb_sel", wb_write_select, 3'd0);
    check("rst_mov_pend", mov_pending, 1'b0);
    check("rst_seq_err", mov_seq_err, 1'b0);
    rst_n = 1'b1;

    // ADD d=1010 then dependent CMP d=1100 (RAW on r3).
    tick();
    apply({OPCODE_ADD, 4'b1010}, 1'b1);
    check("add_rs1", read_select_1, 3'd0);
    check("add_rs2", read_select_2, 3'd2);
    check("add_ready", instr_ready, 1'b1);
    tick();
    apply({OPCODE_CMP, 4'b1100}, 1'b1);
    check("add_busy_t1", busy_mask, 8'b0000_1000);
    check("raw_ready_t1", instr_ready, 1'b0);
    check("add_wb_t1", wb_write_enable, 1'b0);
    tick();
    check("raw_ready_t2", instr_ready, 1'b0);
    check("add_wb_t2", wb_write_enable, 1'b1);
    check("add_wbsel_t2", wb_write_select, 3'd3);
    tick();
    check("raw_ready_t3", instr_ready, 1'b1);
    check("raw_busy_t3", busy_mask, 8'h00);
    check("cmp_rs1", read_select_1, 3'd3);
    check("cmp_rs2", read_select_2, 3'd0);
    check("raw_wb_t3", wb_write_enable, 1'b0);
    tick();
    apply(8'h00, 1'b0);
    check("cmp_nowrite", busy_mask, 8'h00);

    // Back-to-back independent writes: SUB -> r2, XOR -> r3.
    tick();
    apply({OPCODE_SUB, 4'b0000}, 1'b1);
    check("b2b_ready1", instr_ready, 1'b1);
    tick();
    apply({OPCODE_XOR, 4'b1000}, 1'b1);
    check("b2b_ready2", instr_ready, 1'b1);
    check("b2b_busy1", busy_mask, 8'b0000_0100);
    tick();
    apply(8'h00, 1'b0);
    check("b2b_busy2", busy_mask, 8'b0000_1100);
    check("b2b_wb1", wb_write_enable, 1'b1);
    check("b2b_wbsel1", wb_write_select, 3'd2);
    tick();
    check("b2b_wb2", wb_write_enable, 1'b1);
    check("b2b_wbsel2", wb_write_select, 3'd3);
    check("b2b_busy3", busy_mask, 8'b0000_1000);
    tick();
    check("b2b_drain", busy_mask, 8'h00);

    // WAW: two writes to r3 with no shared reads.
    apply({OPCODE_ADD, 4'b1000}, 1'b1);
    tick();
    apply({OPCODE_SUB, 4'b1000}, 1'b1);
    check("waw_ready_t1", instr_ready, 1'b0);
    tick();
    check("waw_ready_t2", instr_ready, 1'b0);
    tick();
    check("waw_ready_t3", instr_ready, 1'b1);
    tick();
    apply(8'h00, 1'b0);
    check("waw_busy", busy_mask, 8'b0000_1000);
    tick();
    check("waw_wb", wb_write_enable, 1'b1);
    tick();
    check("waw_drain", busy_mask, 8'h00);

    // Decode of the remaining formats, observed with no valid.
    apply({OPCODE_LDUR, 4'b1110}, 1'b0);
    check("ldur_rs1", read_select_1, 3'd2);
    check("ldur_rs2", read_select_2, 3'd0);
    apply({OPCODE_STUR, 4'b0111}, 1'b0);
    check("stur_rs1", read_select_1, 3'd3);
    check("stur_rs2", read_select_2, 3'd1);
    apply({OPCODE_BR, 4'b0010}, 1'b0);
    check("br_rs1", read_select_1, 3'd6);
    check("br_rs2", read_select_2, 3'd0);

    // MOV pair: src r5 -> dst r2.
    apply({OPCODE_MOV1, 4'b0101}, 1'b1);
    check("mov1_pend_before", mov_pending, 1'b0);
    tick();
    apply({OPCODE_MOV2, 4'b0010}, 1'b1);
    check("mov_pending", mov_pending, 1'b1);
    check("mov1_nowrite", busy_mask, 8'h00);
    check("mov2_rs1", read_select_1, 3'd5);
    check("mov2_ready", instr_ready, 1'b1);
    tick();
    apply(8'h00, 1'b0);
    check("mov_done", mov_pending, 1'b0);
    check("mov_busy", busy_mask, 8'b0000_0100);
    tick();
    check("mov_wb", wb_write_enable, 1'b1);
    check("mov_wbsel", wb_write_select, 3'd2);
    tick();
    check("mov_drain", busy_mask, 8'h00);

    // Orphan MOV2.
    apply({OPCODE_MOV2, 4'b0001}, 1'b1);
    check("orphan_ready", instr_ready, 1'b1);
    tick();
    apply(8'h00, 1'b0);
    check("orphan_err", mov_seq_err, 1'b1);
    check("orphan_busy", busy_mask, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("orphan_nowb", wb_write_enable, 1'b0);
      check("orphan_sticky", mov_seq_err, 1'b1);
      tick();
    end

    // Bubble stream.
    for (int i = 0; i < 3; i++) begin
      apply(8'h00, 1'b1);
      check("bubble_ready", instr_ready, 1'b1);
      check("bubble_busy", busy_mask, 8'h00);
      check("bubble_wb", wb_write_enable, 1'b0);
      tick();
    end

    // Issue disabled with an ADD held valid.
    enabled = 1'b0;
    apply({OPCODE_ADD, 4'b1010}, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("dis_ready", instr_ready, 1'b1);
      check("dis_busy", busy_mask, 8'h00);
      check("dis_wb", wb_write_enable, 1'b0);
      tick();
    end
    apply(8'h00, 1'b0);
    enabled = 1'b1;

    // Reset mid-flight with a MOV1 latched and an ADD in the pipe.
    tick();
    apply({OPCODE_MOV1, 4'b0101}, 1'b1);
    tick();
    apply({OPCODE_ADD, 4'b1010}, 1'b1);
    check("pend_add_ready", instr_ready, 1'b1);
    tick();
    apply(8'h00, 1'b0);
    check("pre_rst_busy", busy_mask, 8'b0000_1000);
    check("pre_rst_pend", mov_pending, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_mask, 8'h00);
    check("mid_rst_wb", wb_write_enable, 1'b0);
    check("mid_rst_pend", mov_pending, 1'b0);
    check("mid_rst_err", mov_seq_err, 1'b0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_nowb", wb_write_enable, 1'b0);
      check("post_rst_busy", busy_mask, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
